// File: rtl/fetch_stage_if.sv
// Bundle of everything the fetch stage exchanges with instruction memory,
// the conditional/branch logic and the decoder. The fetch stage is the
// master; the environment around it (memory, branch logic, decode) is the slave.
interface fetch_stage_if;
    // instruction-memory read channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // taken-branch redirect
    logic        redirect;
    logic [31:0] redirect_pc;
    // held instruction towards decode
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus8;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output inst_pc_plus8
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  inst_pc_plus8
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, reads one word at a
// time from instruction memory over req/ack, and holds the fetched word for
// decode. A taken branch redirects the PC and squashes wrong-path work; a
// request already in flight when the branch arrives is completed and its
// data thrown away, so the memory never sees an address change mid-request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,   // one cycle after reset before the first request
        S_FETCH,  // request at fetch_pc outstanding
        S_HOLD,   // instruction held for decode, no request
        S_DROP    // finishing a wrong-path request at drop_addr
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;   // next address to fetch
    logic [31:0] drop_addr;  // address of the request being discarded
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] target;     // word-aligned branch target

    // Low address bits of the target are ignored: fetches are word aligned.
    assign target = bus.redirect_pc & ~32'h3;

    // Fetch FSM together with the PC and the instruction output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC & ~32'h3;
            drop_addr <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            // NOTE: all state here uses <= so every branch reads the values
            // from before this edge, e.g. drop_addr captures the old fetch_pc
            // in the same cycle fetch_pc takes the branch target.
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.redirect && bus.imem_ack) begin
                        // wrong-path data arrived together with the branch
                        fetch_pc <= target;
                    end else if (bus.redirect) begin
                        // request cannot be withdrawn: finish it, discard it
                        drop_addr <= fetch_pc;
                        fetch_pc  <= target;
                        state     <= S_DROP;
                    end else if (bus.imem_ack) begin
                        inst_q    <= bus.imem_rdata;
                        inst_pc_q <= fetch_pc;
                        fetch_pc  <= fetch_pc + 32'd4;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        // held word is the wrong-path successor of the branch
                        fetch_pc <= target;
                        state    <= S_FETCH;
                    end else if (bus.inst_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (bus.redirect) begin
                        fetch_pc <= target;
                    end
                    if (bus.imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Request and valid strobes decoded from the current state.
    always_comb begin
        // NOTE: defaults first so no state leaves an output unassigned,
        // which would otherwise infer a latch.
        bus.imem_req   = 1'b0;
        bus.inst_valid = 1'b0;
        bus.imem_addr  = fetch_pc;
        case (state)
            S_FETCH: begin
                bus.imem_req = 1'b1;
            end
            S_DROP: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = drop_addr;
            end
            S_HOLD: begin
                bus.inst_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
    // ARM reads PC as the instruction address plus 8; wraps at 2^32.
    assign bus.inst_pc_plus8 = inst_pc_q + 32'd8;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the control-signal decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Holds each fetched instruction in an output register, where decode reads cond/op/funct.
- Redirects on the taken-branch PCSrc produced by conditional logic and squashes any wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  read data.
- redirect  in  1  taken branch (PCSrc) from conditional logic.
- redirect_pc  in  32  branch target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  inst, inst_pc and inst_pc_plus8 are valid.
- inst_ready  in  1  decode consumes the held instruction.
- inst  out  32  fetched instruction; decode takes [31:28] as cond, [27:26] as op, [25:20] as funct.
- inst_pc  out  32  address of inst.
- inst_pc_plus8  out  32  inst_pc+8, the ARM PC read value; combinational from inst_pc.

Behaviour:
- Registers:
  - fetch_pc[31:0]: next address to fetch.
  - inst[31:0] and inst_pc[31:0]: output register.
  - state: S_IDLE, S_FETCH, S_HOLD, S_DROP.
- Reset (reset_n low, async):
  - state=S_IDLE, fetch_pc=RESET_PC.
  - inst=0, inst_pc=0, inst_valid=0, imem_req=0.
  - Reset asserted mid-operation abandons any outstanding request immediately; the memory must tolerate req dropping.
- Output decode (combinational from state):
  - imem_req=1 only in S_FETCH and S_DROP.
  - inst_valid=1 only in S_HOLD.
- Request address:
  - S_FETCH drives imem_addr=fetch_pc.
  - S_DROP drives imem_addr=drop_addr, the address of the outstanding request.
  - imem_addr is held stable while imem_req=1 until imem_ack.
- S_IDLE: on the first edge with reset_n high, go to S_FETCH. The first request is visible one cycle after reset release.
- S_FETCH, priority top-down:
  - redirect & imem_ack: discard rdata; fetch_pc<=redirect_pc&~3; stay in S_FETCH.
  - redirect & !imem_ack: drop_addr<=fetch_pc; fetch_pc<=redirect_pc&~3; go to S_DROP.
  - imem_ack: inst<=imem_rdata; inst_pc<=fetch_pc; fetch_pc<=fetch_pc+4; go to S_HOLD.
  - Otherwise: hold.
- S_HOLD:
  - redirect: squash the held instruction (the wrong-path successor of the branch in decode). fetch_pc<=redirect_pc&~3; go to S_FETCH. Redirect has priority over inst_ready.
  - inst_ready: go to S_FETCH.
  - Otherwise: hold; inst, inst_pc and inst_valid stay stable.
- S_DROP:
  - Keep the request alive at drop_addr.
  - redirect: fetch_pc<=redirect_pc&~3 (latest redirect wins).
  - imem_ack: discard rdata; go to S_FETCH.
- Latency and throughput:
  - Zero-wait memory (ack in the request cycle): inst_valid rises 1 cycle after the request cycle.
  - Best case is 1 instruction per 2 cycles.
  - N wait cycles add N cycles of latency.
- Arithmetic:
  - 32-bit wrapping adds; 32'hFFFF_FFFC+4=32'h0000_0000.
  - inst_pc_plus8 wraps the same way.
- Other rules:
  - redirect is ignored in S_IDLE.
  - imem_ack while imem_req=0 is ignored.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory returning addr^0xE000_0000, inst_ready=1:
  - imem_addr sequence 0x100, 0x104, 0x108.
  - inst 0xE000_0100 with inst_pc 0x100 and inst_pc_plus8 0x108; then 0xE000_0104.
- Memory with 3 wait cycles: imem_addr stays stable 4 cycles; inst_valid rises 1 cycle after ack.
- inst_ready=0 for 5 cycles in S_HOLD: inst, inst_valid and inst_pc stay stable; imem_req=0 throughout.
- Redirect to 0x203 in S_HOLD while inst_ready=1:
  - inst_valid falls next cycle (squash).
  - Next imem_addr=0x200.
- Redirect to 0x400 while a request at 0x10C waits 2 more cycles:
  - imem_addr stays 0x10C until ack; that data is never presented.
  - Next request is 0x400.
  - A second redirect to 0x500 during S_DROP makes the next request 0x500.
- Wrap: RESET_PC=0xFFFF_FFFC gives the request sequence 0xFFFF_FFFC then 0x0000_0000, with inst_pc_plus8=0x0000_0004.
- Reset asserted during S_DROP: imem_req=0 and inst_valid=0 immediately; after release, the first request goes to RESET_PC.
